// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//
// Optional feature macro: FIFO_FWFT_EN
//   defined   -> first-word-fall-through: out shows the head entry whenever the
//                FIFO is non-empty (read latency 0)
//   undefined -> standard: a popped word appears on out one edge after the pop,
//                with a one-cycle out_valid pulse (read latency 1)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in           write data (WIDTH)
//   push, pop    write / read requests
//   out          read data (WIDTH)
//   out_valid    out carries valid data
//   is_empty     count == 0
//   is_full      count == DEPTH
//   almost_full  count >= AFULL_TH
//   almost_empty count <= AEMPTY_TH
//   count        occupancy 0..DEPTH (BASE+1 bits)
//   overflow     sticky: push rejected because full
//   underflow    sticky: pop rejected because empty
module sync_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BASE      = 2,
    parameter int unsigned AFULL_TH  = (32'd1 << BASE) - 32'd1,
    parameter int unsigned AEMPTY_TH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             is_empty,
    output logic             is_full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [BASE:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned DEPTH = 32'd1 << BASE;
    localparam int unsigned CW    = BASE + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [BASE-1:0] wr_ptr_q, wr_ptr_d;
    logic [BASE-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            empty_q, full_q, afull_q, aempty_q;
    logic            ovf_q, udf_q;
    logic            push_ok, pop_ok;

    // Accept decisions and next occupancy, all from pre-edge state
    always_comb begin
        pop_ok   = 1'b0;
        push_ok  = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        pop_ok  = pop && !empty_q;
        // A full FIFO can still take a push when a pop frees a slot this edge
        push_ok = push && (!full_q || pop_ok);

        if (push_ok) wr_ptr_d = wr_ptr_q + BASE'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + BASE'(1);

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and flags; flags are derived from the next count so
    // they always agree with count in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == CW'(DEPTH));
            afull_q  <= (32'(count_d) >= AFULL_TH);
            aempty_q <= (32'(count_d) <= AEMPTY_TH);
            ovf_q    <= ovf_q | (push && !push_ok);
            udf_q    <= udf_q | (pop && !pop_ok);
        end
    end

    // Storage array; contents deliberately not reset
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr_q] <= in;
    end

`ifdef FIFO_FWFT_EN
    // Head entry falls through; nothing is shown while empty
    always_comb begin
        out       = empty_q ? '0 : mem[rd_ptr_q];
        out_valid = !empty_q;
    end
`else
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;

    // Registered read port: popped word held until the next pop
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= pop_ok;
            if (pop_ok) out_q <= mem[rd_ptr_q];
        end
    end

    always_comb begin
        out       = out_q;
        out_valid = out_valid_q;
    end
`endif

    always_comb begin
        is_empty     = empty_q;
        is_full      = full_q;
        almost_full  = afull_q;
        almost_empty = aempty_q;
        count        = count_q;
        overflow     = ovf_q;
        underflow    = udf_q;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo (WIDTH=8, BASE=2): directed scenarios followed by random
// push/pop/reset traffic, checked every cycle against a queue-based model.
module tb_sync_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned BASE  = 2;
    localparam int          DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             out_valid, is_empty, is_full, almost_full, almost_empty;
    logic [BASE:0]    count;
    logic             overflow, underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_out   = 8'h00;
    logic       m_ovld  = 1'b0;
    logic       m_ovf   = 1'b0;
    logic       m_udf   = 1'b0;
    int         max_cnt = 0;

    sync_fifo #(.WIDTH(WIDTH), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .in(din), .push(push), .pop(pop),
        .out(dout), .out_valid(out_valid), .is_empty(is_empty), .is_full(is_full),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge using the pre-edge contents
    task automatic model_step(input logic rs, input logic p, input logic r, input logic [7:0] d);
        int  n;
        bit  p_ok, r_ok;
        logic [7:0] head;
        if (rs) begin
            q.delete();
            m_out = 8'h00; m_ovld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
            return;
        end
        n    = q.size();
        r_ok = r && (n > 0);
        p_ok = p && ((n < DEPTH) || r_ok);
        m_ovld = 1'b0;
        if (r_ok) begin
            head = q.pop_front();
            m_out  = head;
            m_ovld = 1'b1;
        end
        if (p_ok) q.push_back(d);
        if (p && !p_ok) m_ovf = 1'b1;
        if (r && !r_ok) m_udf = 1'b1;
    endtask

    task automatic check_all();
        int n;
        logic [7:0] e_out;
        logic       e_vld;
        n = q.size();
`ifdef FIFO_FWFT_EN
        e_out = (n > 0) ? q[0] : 8'h00;
        e_vld = (n > 0);
`else
        e_out = m_out;
        e_vld = m_ovld;
`endif
        check("count",        32'(count),        32'(n));
        check("is_empty",     32'(is_empty),     32'(n == 0));
        check("is_full",      32'(is_full),      32'(n == DEPTH));
        check("almost_full",  32'(almost_full),  32'(n >= DEPTH - 1));
        check("almost_empty", 32'(almost_empty), 32'(n <= 1));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_udf));
        check("out_valid",    32'(out_valid),    32'(e_vld));
        if (e_vld) check("out", 32'(dout), 32'(e_out));
        if (n > max_cnt) max_cnt = n;
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later
    task automatic cyc(input logic rs, input logic p, input logic r, input logic [7:0] d);
        rst = rs; push = p; pop = r; din = d;
        @(posedge clk);
        model_step(rs, p, r, d);
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] seq [4];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

        // Reset
        cyc(1'b1, 1'b1, 1'b0, 8'hEE);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        check("rst_out", 32'(dout), 32'h0);

        // Fill
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, seq[i]);
        check("fill_full", 32'(is_full), 32'h1);

        // Overflow: rejected push, sticky flag
        cyc(1'b0, 1'b1, 1'b0, 8'h55);
        check("ovf_set", 32'(overflow), 32'h1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
        check("ovf_last_out", 32'(dout), 32'h44);
`endif
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Simultaneous push/pop at full
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, seq[i]);
        cyc(1'b0, 1'b1, 1'b1, 8'h66);
        check("full_pp_count", 32'(count), 32'h4);
`ifndef FIFO_FWFT_EN
        check("full_pp_out", 32'(dout), 32'h11);
`endif
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
        check("full_pp_last", 32'(dout), 32'h66);
`endif

        // Empty boundary: push+pop on empty
        cyc(1'b0, 1'b1, 1'b1, 8'hA5);
        check("empty_pp_udf", 32'(underflow), 32'h1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
        check("empty_pp_out", 32'(dout), 32'hA5);
`endif
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Wrap-around with a 2-entry backlog
        max_cnt = 0;
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h01);
        for (int i = 2; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 8'(i));
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        check("wrap_max_cnt", 32'(max_cnt), 32'h2);
`ifndef FIFO_FWFT_EN
        check("wrap_last", 32'(dout), 32'h09);
`endif

        // Reset mid-operation with push held high
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, seq[i]);
        cyc(1'b1, 1'b1, 1'b0, 8'h77);
        check("midrst_count", 32'(count), 32'h0);
        check("midrst_out", 32'(dout), 32'h0);
        check("midrst_ovld", 32'(out_valid), 32'h0);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
